imem_loader: RTL and testbench

- Writer side of the instruction memory. It receives a program image as a byte stream with a valid/ready handshake, packs the bytes into 32-bit little-endian words, and issues word-aligned write strobes to the writable instruction memory.
- It holds the CPU in reset while a load is in progress, then verifies an XOR checksum and reports done or error.
- It sits between the host link (UART byte receiver) and the instruction memory write port.

---
 rtl/imem_loader.sv | 151 +++++++++++++++
 tb/tb_imem_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader: packs LE bytes into 32-bit words, writes instruction memory,
// holds the CPU in reset during the load and verifies a trailing XOR checksum.
module imem_loader #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        we,
  output logic [31:0] wa,
  output logic [31:0] wd,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR} state_t;

  state_t      state, state_nx;
  logic [15:0] len, len_nx;
  logic [1:0]  lane, lane_nx;
  logic [31:0] word, word_nx;
  logic [7:0]  csum, csum_nx;
  logic        s_ready_nx, we_nx, cpu_hold_nx, done_nx, error_nx;
  logic [31:0] wa_nx, wd_nx;
  logic [15:0] wl_nx;
  logic [15:0] len_rx;
  logic        accept;

  assign accept = s_valid && s_ready;
  assign len_rx = {s_data, len[7:0]};

  always_comb begin
    state_nx    = state;
    len_nx      = len;
    lane_nx     = lane;
    word_nx     = word;
    csum_nx     = csum;
    we_nx       = 1'b0;
    wa_nx       = wa;
    wd_nx       = wd;
    cpu_hold_nx = cpu_hold;
    done_nx     = done;
    error_nx    = error;
    wl_nx       = words_loaded;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_nx    = LEN0;
          cpu_hold_nx = 1'b1;
          done_nx     = 1'b0;
          error_nx    = 1'b0;
          wl_nx       = 16'd0;
          lane_nx     = 2'd0;
          csum_nx     = 8'd0;
        end
      end
      LEN0: begin
        if (accept) begin
          len_nx[7:0] = s_data;
          state_nx    = LEN1;
        end
      end
      LEN1: begin
        if (accept) begin
          len_nx[15:8] = s_data;
          if (len_rx > 16'(DEPTH)) begin
            state_nx    = ERR;
            cpu_hold_nx = 1'b0;
            error_nx    = 1'b1;
          end else if (len_rx == 16'd0) begin
            state_nx = CSUM;
          end else begin
            state_nx = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          word_nx[{lane, 3'b000} +: 8] = s_data;
          csum_nx = csum ^ s_data;
          lane_nx = lane + 2'd1;
          if (lane == 2'd3) begin
            // Strobe and address are registered on entry so they line up with WRITE.
            state_nx = WRITE;
            we_nx    = 1'b1;
            wa_nx    = BASE_ADDR + {14'd0, words_loaded, 2'b00};
            wd_nx    = word_nx;
          end
        end
      end
      WRITE: begin
        wl_nx    = words_loaded + 16'd1;
        state_nx = (wl_nx == len) ? CSUM : DATA;
      end
      CSUM: begin
        if (accept) begin
          cpu_hold_nx = 1'b0;
          if (s_data == csum) begin
            state_nx = DONE;
            done_nx  = 1'b1;
          end else begin
            state_nx = ERR;
            error_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    s_ready_nx = (state_nx == LEN0) || (state_nx == LEN1) ||
                 (state_nx == DATA) || (state_nx == CSUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      len          <= 16'd0;
      lane         <= 2'd0;
      word         <= 32'd0;
      csum         <= 8'd0;
      s_ready      <= 1'b0;
      we           <= 1'b0;
      wa           <= BASE_ADDR;
      wd           <= 32'd0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= 16'd0;
    end else begin
      state        <= state_nx;
      len          <= len_nx;
      lane         <= lane_nx;
      word         <= word_nx;
      csum         <= csum_nx;
      s_ready      <= s_ready_nx;
      we           <= we_nx;
      wa           <= wa_nx;
      wd           <= wd_nx;
      cpu_hold     <= cpu_hold_nx;
      done         <= done_nx;
      error        <= error_nx;
      words_loaded <= wl_nx;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: nominal, bad checksum, oversize, zero length,
// backpressure, mid-load reset and ignored mid-load start.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready, we, cpu_hold, done, error;
  logic [31:0] wa, wd;
  logic [15:0] words_loaded;

  int checks = 0;
  int errs = 0;
  int rdy_bad = 0;
  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];
  logic [7:0]  stim[$];

  imem_loader #(.DEPTH(64), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .we(we), .wa(wa), .wd(wd), .cpu_hold(cpu_hold),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Record every write strobe; s_ready must be low whenever we is high.
  always @(negedge clk) begin
    if (we) begin
      wr_a.push_back(wa);
      wr_d.push_back(wd);
      if (s_ready) rdy_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer stim bytes in order; a byte advances only when s_valid && s_ready at the edge.
  task automatic run_stream(input bit toggle);
    int  i = 0;
    int  guard = 0;
    bit  ph = 1'b0;
    while (i < stim.size() && guard < 2000) begin
      @(negedge clk);
      guard++;
      ph = toggle ? !ph : 1'b1;
      s_valid = ph;
      s_data  = stim[i];
      if (ph && s_ready) i++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    check("stream_timeout", 32'(guard < 2000), 32'd1);
  endtask

  task automatic load_nominal(input logic [7:0] last);
    stim = '{8'h02, 8'h00, 8'h1E, 8'h10, 8'hA0, 8'hE3, 8'h11, 8'h20, 8'hA0, 8'hE3, last};
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, wr_a.size(), 32'd2);
    if (wr_a.size() == 2) begin
      check({tag, "_wa0"}, wr_a[0], 32'h0);
      check({tag, "_wd0"}, wr_d[0], 32'hE3A0101E);
      check({tag, "_wa1"}, wr_a[1], 32'h4);
      check({tag, "_wd1"}, wr_d[1], 32'hE3A02011);
    end
  endtask

  task automatic check_done(input string tag);
    check_writes(tag);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_error"}, error, 1'b0);
    check({tag, "_hold"}, cpu_hold, 1'b0);
    check({tag, "_words"}, words_loaded, 16'd2);
    check({tag, "_rdy"}, s_ready, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"}, s_ready, 1'b0);
    check({tag, "_we"}, we, 1'b0);
    check({tag, "_wa"}, wa, 32'h0);
    check({tag, "_wd"}, wd, 32'h0);
    check({tag, "_hold"}, cpu_hold, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_error"}, error, 1'b0);
    check({tag, "_words"}, words_loaded, 16'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;

    // Nominal load
    wr_a.delete(); wr_d.delete();
    do_start();
    check("nom_hold_on", cpu_hold, 1'b1);
    check("nom_rdy_on", s_ready, 1'b1);
    load_nominal(8'h3F);
    run_stream(1'b0);
    check_done("nom");

    // Bad checksum; the start also clears the sticky done
    wr_a.delete(); wr_d.delete();
    do_start();
    check("bad_done_clr", done, 1'b0);
    load_nominal(8'h40);
    run_stream(1'b0);
    check_writes("bad");
    check("bad_error", error, 1'b1);
    check("bad_done", done, 1'b0);
    check("bad_hold", cpu_hold, 1'b0);

    // Oversize word count
    wr_a.delete(); wr_d.delete();
    do_start();
    check("big_err_clr", error, 1'b0);
    stim = '{8'h41, 8'h00};
    run_stream(1'b0);
    check("big_nwr", wr_a.size(), 32'd0);
    check("big_error", error, 1'b1);
    check("big_rdy", s_ready, 1'b0);
    check("big_hold", cpu_hold, 1'b0);
    check("big_words", words_loaded, 16'd0);

    // Zero-length load
    wr_a.delete(); wr_d.delete();
    do_start();
    stim = '{8'h00, 8'h00, 8'h00};
    run_stream(1'b0);
    check("zero_nwr", wr_a.size(), 32'd0);
    check("zero_done", done, 1'b1);
    check("zero_error", error, 1'b0);
    check("zero_words", words_loaded, 16'd0);

    // Backpressure: s_valid toggles every other cycle
    wr_a.delete(); wr_d.delete();
    do_start();
    load_nominal(8'h3F);
    run_stream(1'b1);
    check_done("bp");

    // Reset after the 6th byte (first word complete)
    wr_a.delete(); wr_d.delete();
    do_start();
    stim = '{8'h02, 8'h00, 8'h1E, 8'h10, 8'hA0, 8'hE3};
    run_stream(1'b0);
    check("mid_hold", cpu_hold, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_idle_rdy", s_ready, 1'b0);

    // Fresh load after reset
    wr_a.delete(); wr_d.delete();
    do_start();
    load_nominal(8'h3F);
    run_stream(1'b0);
    check_done("rel");

    // Start pulse mid-load must not restart the load
    wr_a.delete(); wr_d.delete();
    do_start();
    load_nominal(8'h3F);
    fork
      run_stream(1'b0);
      begin
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    check_done("mst");

    repeat (3) @(negedge clk);
    check("we_low_idle", we, 1'b0);
    check("rdy_during_we", rdy_bad, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
